clb_cfg_loader: RTL

Serial configuration controller for the CLB array. Hunts a preamble in an incoming bitstream, reads a frame count, then deserialises one parity-checked configuration word per CLB. Each checked word goes out with its address and a one-cycle write strobe. Holds the array quiescent until loading completes, then signals DONE; any framing or parity fault parks the block in ERR.

---
 rtl/clb_cfg_pkg.sv | 48 ++++
 rtl/clb_cfg_loader_if.sv | 31 +++
 rtl/clb_cfg_shift.sv | 57 +++++
 rtl/clb_cfg_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clb_cfg_pkg : shared constants, FSM states and CFG_DATA field map
// Rev 1.0
// ---------------------------------------------------------------------------
package clb_cfg_pkg;

  localparam int         CFG_W    = 37;
  localparam int         LEN_W    = 16;
  localparam logic [7:0] PREAMBLE = 8'hF2;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    LEN   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    DONE  = 3'd5,
    ERROR = 3'd6
  } state_e;

  // Field layout of one CLB configuration word
  localparam int MEM_HI         = 36;
  localparam int MEM_LO         = 21;
  localparam int COMBOPTION_HI  = 20;
  localparam int COMBOPTION_LO  = 19;
  localparam int MUX2SELECT_HI  = 18;
  localparam int MUX2SELECT_LO  = 17;
  localparam int MUX3SELECT_HI  = 16;
  localparam int MUX3SELECT_LO  = 15;
  localparam int MUX4SELECT_HI  = 14;
  localparam int MUX4SELECT_LO  = 13;
  localparam int MUX5SELECT_HI  = 12;
  localparam int MUX5SELECT_LO  = 11;
  localparam int MUX6SELECT_HI  = 10;
  localparam int MUX6SELECT_LO  = 9;
  localparam int O2M_HI         = 8;
  localparam int O2M_LO         = 3;
  localparam int DQMUX_HI       = 2;
  localparam int DQMUX_LO       = 1;
  localparam int FLOPORLATCH    = 0;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clb_cfg_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clb_cfg_loader_if : bitstream input and CLB write/status bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface clb_cfg_loader_if #(
  parameter int CFG_W = 37,
  parameter int AW    = 4
);
  logic             PROG;
  logic             DIN;
  logic             DIN_VALID;
  logic [AW-1:0]    CFG_ADDR;
  logic [CFG_W-1:0] CFG_DATA;
  logic             CFG_WE;
  logic             HOLD;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output PROG, DIN, DIN_VALID,
    input  CFG_ADDR, CFG_DATA, CFG_WE, HOLD, BUSY, DONE, ERR
  );

  modport slave (
    input  PROG, DIN, DIN_VALID,
    output CFG_ADDR, CFG_DATA, CFG_WE, HOLD, BUSY, DONE, ERR
  );
endinterface
`default_nettype wire

// File: rtl/clb_cfg_shift.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clb_cfg_shift : MSB-first deserialiser with running even parity
// Rev 1.0
// ---------------------------------------------------------------------------
module clb_cfg_shift #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] data,
  output logic         par
);
  import clb_cfg_pkg::*;

  logic [W-1:0] data_q, data_d;
  logic         par_q, par_d;
  logic [W-1:0] shift_in;

  generate
    if (W == 1) begin : g_w1
      assign shift_in = din;
    end else begin : g_wn
      assign shift_in = {data_q[W-2:0], din};
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    if (clr) begin
      data_d = '0;
      par_d  = 1'b0;
    end else if (en) begin
      data_d = shift_in;
      par_d  = par_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data = data_q;
  assign par  = par_q;

endmodule
`default_nettype wire

// File: rtl/clb_cfg_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clb_cfg_loader : hunts preamble, reads frame count, writes parity-checked CLB words
// Rev 1.0
// ---------------------------------------------------------------------------
module clb_cfg_loader #(
  parameter int NUM_CLB = 16,
  parameter int CFG_W   = clb_cfg_pkg::CFG_W,
  parameter int AW      = clb_cfg_pkg::addr_w(NUM_CLB)
) (
  input  logic            K,
  input  logic            RESET_N,
  clb_cfg_loader_if.slave cfg
);
  import clb_cfg_pkg::*;

  localparam int CNT_MAX = (CFG_W > LEN_W) ? CFG_W : LEN_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [7:0]       pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    cfg_addr_q, cfg_addr_d;
  logic [CFG_W-1:0] cfg_data_q, cfg_data_d;
  logic             we_q, we_d;
  logic             hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             sh_clr, sh_en, sh_par;
  logic [CFG_W-1:0] sh_data;
  logic [7:0]       pre_next;
  logic [LEN_W-1:0] len_next;
  logic             len_over;

  assign pre_next = {pre_q[6:0], cfg.DIN};
  assign len_next = {len_q[LEN_W-2:0], cfg.DIN};
  assign len_over = (32'(len_next) > 32'(NUM_CLB));

  clb_cfg_shift #(.W(CFG_W)) u_shift (
    .clk   (K),
    .rst_n (RESET_N),
    .clr   (sh_clr),
    .en    (sh_en),
    .din   (cfg.DIN),
    .data  (sh_data),
    .par   (sh_par)
  );

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    sh_clr     = 1'b0;
    sh_en      = 1'b0;

    // PROG outranks everything, including a coincident valid bit
    if (cfg.PROG) begin
      state_d    = HUNT;
      pre_d      = '0;
      cnt_d      = '0;
      len_d      = '0;
      addr_d     = '0;
      cfg_addr_d = '0;
      hold_d     = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      sh_clr     = 1'b1;
    end else begin
      case (state_q)
        HUNT: begin
          if (cfg.DIN_VALID) begin
            pre_d = pre_next;
            if (pre_next == PREAMBLE) begin
              state_d = LEN;
              busy_d  = 1'b1;
              cnt_d   = '0;
            end
          end
        end
        LEN: begin
          if (cfg.DIN_VALID) begin
            len_d = len_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LEN_W - 1)) begin
              cnt_d = '0;
              if (len_next == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
                busy_d  = 1'b0;
              end else if (len_over) begin
                state_d = ERROR;
                err_d   = 1'b1;
                busy_d  = 1'b0;
              end else begin
                state_d = START;
              end
            end
          end
        end
        START: begin
          if (cfg.DIN_VALID) begin
            if (cfg.DIN) begin
              state_d = ERROR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = DATA;
              sh_clr  = 1'b1;
              cnt_d   = '0;
            end
          end
        end
        DATA: begin
          if (cfg.DIN_VALID) begin
            sh_en = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CFG_W - 1)) begin
              cnt_d   = '0;
              state_d = PAR;
            end
          end
        end
        PAR: begin
          if (cfg.DIN_VALID) begin
            // Even parity: data parity must equal the parity bit itself
            if (sh_par == cfg.DIN) begin
              we_d       = 1'b1;
              cfg_data_d = sh_data;
              cfg_addr_d = addr_q;
              addr_d     = addr_q + AW'(1);
              len_d      = len_q - LEN_W'(1);
              state_d    = (len_q == LEN_W'(1)) ? DONE : START;
            end else begin
              state_d = ERROR;
              err_d   = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
        DONE: begin
          done_d = 1'b1;
          hold_d = 1'b0;
          busy_d = 1'b0;
        end
        ERROR: begin
          err_d  = 1'b1;
          busy_d = 1'b0;
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge K or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= HUNT;
      pre_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cfg.CFG_ADDR = cfg_addr_q;
  assign cfg.CFG_DATA = cfg_data_q;
  assign cfg.CFG_WE   = we_q;
  assign cfg.HOLD     = hold_q;
  assign cfg.BUSY     = busy_q;
  assign cfg.DONE     = done_q;
  assign cfg.ERR      = err_q;

endmodule
`default_nettype wire
